// File: rtl/soc_system_debounced_pio.sv
// Debounced parallel input port with an Avalon-MM slave interface.
//
// Each in_port bit is synchronised, then debounced by a per-bit counter. A
// new level is accepted only after it has been seen for DEBOUNCE_CYCLES
// consecutive cycles. Accepted level changes raise edge events, qualified by
// EDGE_TYPE, which latch into EDGECAPTURE and can raise irq through IRQMASK.
//
// Parameters:
//   WIDTH           number of input bits (1..32)
//   SYNC_STAGES     synchroniser flops per bit (2..4)
//   DEBOUNCE_CYCLES stable cycles required before a level is accepted
//   EDGE_TYPE       0 = rising, 1 = falling, 2 = any edge
//   INIT_VALUE      reset value of the synchronisers and debounced state
//
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   address         word address: 0 DATA, 1 RAW, 2 IRQMASK, 3 EDGECAPTURE (W1C)
//   chipselect      slave select
//   write_n         active-low write strobe
//   writedata       write data
//   in_port         asynchronous button/switch inputs
//   readdata        registered read data, one cycle latency
//   irq             level interrupt, OR of EDGECAPTURE & IRQMASK
module soc_system_debounced_pio #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE      = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CntW-1:0]  cnt_q  [WIDTH];
  logic [CntW-1:0]  cnt_d  [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  assign sync  = sync_q[SYNC_STAGES-1];
  assign wr_en = chipselect & ~write_n;

  // Only the low WIDTH bits of writedata are meaningful.
  assign unused_wdata = ^writedata;

  // Debounce: any cycle where the synchronised input matches the accepted
  // level restarts the count, so only an unbroken run is accepted.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        stable_d[i] = sync[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  // Edge events fire in the same cycle the debounced level is updated.
  always_comb begin
    edge_evt = '0;
    if (EDGE_TYPE == 0) begin
      edge_evt = ~stable_q & stable_d;
    end else if (EDGE_TYPE == 1) begin
      edge_evt = stable_q & ~stable_d;
    end else begin
      edge_evt = stable_q ^ stable_d;
    end
  end

  always_comb begin
    mask_d = mask_q;
    cap_d  = cap_q;
    if (wr_en && (address == 2'd2)) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == 2'd3)) begin
      cap_d = cap_q & ~writedata[WIDTH-1:0];
    end
    // Applied after the clear so a coincident event keeps its bit set.
    cap_d = cap_d | edge_evt;
  end

  // Read mux samples pre-update values, so a read never sees a same-cycle
  // write or edge event.
  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = stable_q;
      2'd1:    readdata_d[WIDTH-1:0] = sync;
      2'd2:    readdata_d[WIDTH-1:0] = mask_q;
      default: readdata_d[WIDTH-1:0] = cap_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= INIT_VALUE;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q   <= INIT_VALUE;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stable_q   <= stable_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_soc_system_debounced_pio.sv
// Bench for soc_system_debounced_pio: two instances (falling-edge and
// any-edge capture) share one stimulus and are compared every cycle against
// a window-based model, plus directed scenarios with literal expectations.
module tb_soc_system_debounced_pio;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int D  = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] readdata_f, readdata_a;
  logic        irq_f, irq_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  soc_system_debounced_pio #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1), .INIT_VALUE(4'hF)
  ) dut_f (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_f), .irq(irq_f)
  );

  soc_system_debounced_pio #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2), .INIT_VALUE(4'hF)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_a), .irq(irq_a)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // syncq: input delay line (front = value currently at the last sync stage).
  // hist: last D synchronised samples; a level is accepted when all of them
  // differ from the currently accepted level.
  logic [3:0]  m_syncq[$];
  logic [3:0]  m_hist[$];
  logic [3:0]  m_stable;
  logic [3:0]  m_mask[2];
  logic [3:0]  m_cap[2];
  logic [31:0] m_rd[2];

  task automatic model_reset();
    m_syncq.delete();
    m_hist.delete();
    for (int k = 0; k < SS; k++) m_syncq.push_back(4'hF);
    for (int k = 0; k < D; k++) m_hist.push_back(4'hF);
    m_stable = 4'hF;
    for (int k = 0; k < 2; k++) begin
      m_mask[k] = '0;
      m_cap[k]  = '0;
      m_rd[k]   = '0;
    end
  endtask

  task automatic model_step();
    logic [3:0] sync_pre;
    logic [3:0] nxt;
    logic [3:0] ev[2];
    bit         flip;
    sync_pre = m_syncq[0];
    for (int k = 0; k < 2; k++) begin
      case (address)
        2'd0:    m_rd[k] = {28'd0, m_stable};
        2'd1:    m_rd[k] = {28'd0, sync_pre};
        2'd2:    m_rd[k] = {28'd0, m_mask[k]};
        default: m_rd[k] = {28'd0, m_cap[k]};
      endcase
    end
    m_hist.push_back(sync_pre);
    while (m_hist.size() > D) void'(m_hist.pop_front());
    nxt = m_stable;
    for (int b = 0; b < W; b++) begin
      flip = 1'b1;
      foreach (m_hist[j]) if (m_hist[j][b] == m_stable[b]) flip = 1'b0;
      if (flip) nxt[b] = ~m_stable[b];
    end
    ev[0] = m_stable & ~nxt;
    ev[1] = m_stable ^ nxt;
    for (int k = 0; k < 2; k++) begin
      if (chipselect && !write_n && address == 2'd2) m_mask[k] = writedata[3:0];
      if (chipselect && !write_n && address == 2'd3) m_cap[k] = m_cap[k] & ~writedata[3:0];
      m_cap[k] = m_cap[k] | ev[k];
    end
    m_stable = nxt;
    void'(m_syncq.pop_front());
    m_syncq.push_back(in_port);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_readdata_f", readdata_f, m_rd[0]);
    chk("model_readdata_a", readdata_a, m_rd[1]);
    chk("model_irq_f", {31'd0, irq_f}, {31'd0, |(m_cap[0] & m_mask[0])});
    chk("model_irq_a", {31'd0, irq_a}, {31'd0, |(m_cap[1] & m_mask[1])});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] ef, input logic [31:0] ea,
                    input string name);
    address = a;
    tick();
    chk({name, "_f"}, readdata_f, ef);
    chk({name, "_a"}, readdata_a, ea);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    bit seen;
    #1 reset_n = 1'b0;
    #21 reset_n = 1'b1;

    // Reset state held for 20 cycles.
    address = 2'd0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("reset_data_f", readdata_f, 32'h0000_000F);
      chk("reset_irq_f", {31'd0, irq_f}, 32'd0);
      chk("reset_irq_a", {31'd0, irq_a}, 32'd0);
    end
    rd(2'd3, 32'h0, 32'h0, "reset_cap");

    // 3-cycle glitch on bit 0: visible on RAW, rejected by the debouncer.
    address = 2'd1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      in_port = (k < 3) ? 4'hE : 4'hF;
      tick();
      if (readdata_f == 32'hE) seen = 1'b1;
    end
    chk("glitch_raw_seen", {31'd0, seen}, 32'd1);
    rd(2'd0, 32'hF, 32'hF, "glitch_data");
    rd(2'd3, 32'h0, 32'h0, "glitch_cap");

    // Bit 0 held low: accepted 2+4 edges after the change, read one later.
    address = 2'd0;
    in_port = 4'hE;
    ticks(6);
    chk("hold_data_edge6", readdata_f, 32'hF);
    tick();
    chk("hold_data_edge7", readdata_f, 32'hE);
    rd(2'd3, 32'h1, 32'h1, "hold_cap");
    chk("hold_irq_masked", {31'd0, irq_f}, 32'd0);

    // Mask enables irq; W1C clears it.
    wr(2'd2, 32'h1);
    chk("mask_irq_f", {31'd0, irq_f}, 32'd1);
    chk("mask_irq_a", {31'd0, irq_a}, 32'd1);
    wr(2'd3, 32'h1);
    chk("w1c_irq_f", {31'd0, irq_f}, 32'd0);
    rd(2'd3, 32'h0, 32'h0, "w1c_cap");

    // Bit 2 falls; its edge event coincides with a W1C of bit 2.
    in_port = 4'hA;
    ticks(5);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h4, 32'h4, "setwins_cap");
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h0, 32'h0, "setwins_clear");

    // Bit 1 pressed, captured, cleared, then released.
    in_port = 4'h8;
    ticks(8);
    rd(2'd3, 32'h2, 32'h2, "press1_cap");
    wr(2'd3, 32'h2);
    in_port = 4'hA;
    ticks(8);
    rd(2'd0, 32'hA, 32'hA, "release1_data");
    rd(2'd3, 32'h0, 32'h2, "release1_cap");

    // Reset while bit 3 is mid-debounce with inputs back at the reset value.
    in_port = 4'h2;
    ticks(4);
    in_port = 4'hF;
    pulse_reset();
    ticks(12);
    rd(2'd3, 32'h0, 32'h0, "rst_mid_cap");
    rd(2'd0, 32'hF, 32'hF, "rst_mid_data");
    chk("rst_mid_irq", {31'd0, irq_a}, 32'd0);

    // Reset discards a partial count: the full 2+4 delay applies again.
    in_port = 4'h7;
    ticks(3);
    pulse_reset();
    address = 2'd0;
    ticks(6);
    chk("rst_cnt_edge6", readdata_f, 32'hF);
    tick();
    chk("rst_cnt_edge7", readdata_f, 32'h7);

    // Randomised traffic, checked only by the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) in_port[$urandom_range(0, 3)] ^= 1'b1;
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = ($urandom_range(0, 1) == 0);
      writedata  = $urandom;
      if ($urandom_range(0, 799) == 0) pulse_reset();
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_system_debounced_pio.md
SOC_SYSTEM_DEBOUNCED_PIO -- requirements
Module: soc_system_debounced_pio

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the number of input bits (legal range 1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchroniser flops per bit (legal range 2..4).
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the number of clk cycles an input must stay stable before it is accepted (legal range 1..2^20).
REQ-004 The block SHALL have parameter EDGE_TYPE, default 1, meaning 0 = rising, 1 = falling, 2 = any edge.
REQ-005 The block SHALL have parameter INIT_VALUE, default all-ones (WIDTH bits), meaning the reset value of the synchronisers and the debounced state.
REQ-006 The block SHALL have the port clk, input, 1 bit, system clock.
REQ-007 The block SHALL have the port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have the port address, input, 2 bits, Avalon-MM word address.
REQ-009 The block SHALL have the port chipselect, input, 1 bit, Avalon-MM select.
REQ-010 The block SHALL have the port write_n, input, 1 bit, Avalon-MM active-low write strobe.
REQ-011 The block SHALL have the port writedata, input, 32 bits, Avalon-MM write data.
REQ-012 The block SHALL have the port in_port, input, WIDTH bits, asynchronous button/switch inputs.
REQ-013 The block SHALL have the port readdata, output, 32 bits, registered read data.
REQ-014 The block SHALL have the port irq, output, 1 bit, active-high level interrupt.

Function
REQ-015 Each in_port bit SHALL pass through SYNC_STAGES flops before any other use; the last stage is sync[i].
REQ-016 Each bit SHALL have an independent counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits and a stable[i] flop.
REQ-017 Debounce rule: when sync[i] == stable[i], cnt[i] SHALL clear to 0; otherwise cnt[i] increments, and on the cycle cnt[i] == DEBOUNCE_CYCLES-1, stable[i] <= sync[i] and cnt[i] <= 0.
REQ-018 A glitch on a bit shorter than DEBOUNCE_CYCLES cycles SHALL NOT change stable[i]; any return to the stable value restarts the count.
REQ-019 An edge event on bit i SHALL be a one-cycle pulse on the cycle stable[i] changes, qualified by EDGE_TYPE (rising 0->1, falling 1->0, or either).
REQ-020 Register map (unused upper bits SHALL read 0):
- address 0: DATA, stable, read-only.
- address 1: RAW, sync, read-only.
- address 2: IRQMASK, WIDTH bits, read/write.
- address 3: EDGECAPTURE, WIDTH bits, read / write-1-to-clear.
REQ-021 Writes SHALL take effect when chipselect=1 and write_n=0; writes to addresses 0 and 1 SHALL be ignored.
REQ-022 EDGECAPTURE[i] SHALL set on an edge event and hold until cleared by writing 1 to bit i at address 3.
REQ-023 When an edge event and a W1C of the same bit occur in the same cycle, the set SHALL win and the bit remains 1.
REQ-024 readdata SHALL be registered every clk cycle from the address mux, independent of chipselect, giving a read latency of 1 cycle.
REQ-025 A read SHALL return register values as they were before any same-cycle write or edge event.
REQ-026 irq SHALL be the combinational OR of (EDGECAPTURE & IRQMASK) over all bits, driven from flops only.

Reset
REQ-027 On reset_n=0, the block SHALL asynchronously set sync stages and stable to INIT_VALUE, and clear cnt, IRQMASK, EDGECAPTURE and readdata to 0, so irq=0.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count; no edge event SHALL be generated on deassertion while in_port equals INIT_VALUE.

Verification
REQ-029 The bench SHALL cover these scenarios, with WIDTH=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2, EDGE_TYPE=1, INIT_VALUE=4'hF:
- Reset with in_port=4'hF -> DATA reads 0x0000000F, EDGECAPTURE reads 0, irq=0 for 20 cycles.
- in_port[0] low for 3 cycles then high -> RAW shows the glitch, DATA stays 0xF, EDGECAPTURE stays 0.
- in_port[0] low and held -> DATA becomes 0xE exactly 2+4 cycles after the change; EDGECAPTURE=0x1; irq=0 while IRQMASK=0.
- Write IRQMASK=0x1 -> irq=1 next cycle; write EDGECAPTURE=0x1 -> EDGECAPTURE=0, irq=0.
- Edge event on bit 2 in the same cycle as a W1C of 0x4 -> EDGECAPTURE[2]=1 afterwards.
- in_port[1] released 0->1 with EDGE_TYPE=1 -> DATA updates, no capture; rerun with EDGE_TYPE=2 -> capture bit 1 set.
